// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle
// valid / framing-error strobes. uart_rx_data holds the last well-framed byte.
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rx_en,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] C_HALF = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic                    r_sync1;
  logic                    r_rxd_s;
  state_t                  r_state;
  logic [CW-1:0]           r_cyc;
  logic [BW-1:0]           r_bitn;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_valid;
  logic                    r_ferr;
  logic                    r_busy;

  state_t                  w_state_nxt;
  logic [CW-1:0]           w_cyc_nxt;
  logic [BW-1:0]           w_bitn_nxt;
  logic [PAYLOAD_BITS-1:0] w_shift_nxt;
  logic [PAYLOAD_BITS-1:0] w_data_nxt;
  logic                    w_valid_nxt;
  logic                    w_ferr_nxt;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // Next-state, counter, shift-register and strobe logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    if (!uart_rx_en) begin
      w_state_nxt = S_IDLE;
      w_cyc_nxt   = '0;
      w_bitn_nxt  = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cyc_nxt = '0;
          if (!r_rxd_s) begin
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_START: begin
          if (r_cyc == C_HALF) begin
            w_cyc_nxt  = '0;
            w_bitn_nxt = '0;
            if (!r_rxd_s) begin
              w_state_nxt = S_DATA;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cyc == C_FULL) begin
            // LSB arrives first, so each new bit enters at the MSB and shifts down
            w_shift_nxt = PAYLOAD_BITS'({r_rxd_s, r_shift} >> 1);
            w_cyc_nxt   = '0;
            if (r_bitn == B_LAST) begin
              w_bitn_nxt  = '0;
              w_state_nxt = S_STOP;
            end else begin
              w_bitn_nxt  = r_bitn + BW'(1);
            end
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cyc == C_FULL) begin
            w_cyc_nxt = '0;
            if (r_rxd_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
            end
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          // a break holds the line low; report it once and wait for idle
          if (r_rxd_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cyc_nxt   = '0;
          w_bitn_nxt  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign uart_rx_data      = r_data;
  assign uart_rx_valid     = r_valid;
  assign uart_rx_frame_err = r_ferr;
  assign uart_rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver queues expected strobes (kind, byte,
// arrival cycle) per frame; an independent monitor pops and checks them.
module tb_uart_rx;

  localparam int CLK_HZ   = 1000;
  localparam int BIT_RATE = 100;
  localparam int PB       = 8;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  // first edge seeing the start bit -> strobe: 2 sync stages + middle of stop bit
  localparam int LAT      = 2 + 9 * CPB + CPB / 2;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          uart_rx_en;
  logic          uart_rxd;
  logic [PB-1:0] uart_rx_data;
  logic          uart_rx_valid;
  logic          uart_rx_frame_err;
  logic          uart_rx_busy;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] mon_last = 8'h00;
  int         cyc_cnt = 0;
  int         n_chk = 0;
  int         n_err = 0;

  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .uart_rx_en        (uart_rx_en),
    .uart_rxd          (uart_rxd),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_frame_err (uart_rx_frame_err),
    .uart_rx_busy      (uart_rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic drive_bits(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      uart_rxd = v[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    e.due    = cyc_cnt + 1 + LAT;
    q.push_back(e);
    drive_bits({stop_ok, b, 1'b0}, 10);
  endtask

  // Monitor: pops the scoreboard on every strobe, otherwise checks data is held.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_last = 8'h00;
    end else if (uart_rx_valid || uart_rx_frame_err) begin
      chk("strobe_exclusive", {31'd0, uart_rx_valid & uart_rx_frame_err}, 32'd0);
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b with nothing queued (cycle %0d)",
                 uart_rx_valid, uart_rx_frame_err, cyc_cnt);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_kind", {31'd0, uart_rx_frame_err}, {31'd0, mon_e.is_err});
        chk("strobe_time", cyc_cnt, mon_e.due);
        if (mon_e.is_err) begin
          chk("ferr_data_held", {24'd0, uart_rx_data}, {24'd0, mon_last});
          chk("ferr_busy", {31'd0, uart_rx_busy}, 32'd1);
        end else begin
          chk("rx_data", {24'd0, uart_rx_data}, {24'd0, mon_e.data});
          chk("valid_busy", {31'd0, uart_rx_busy}, 32'd0);
          mon_last = mon_e.data;
        end
      end
    end else begin
      chk("data_stable", {24'd0, uart_rx_data}, {24'd0, mon_last});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         bcnt;
    logic [9:0] v;
    logic [7:0] b;
    bit         ok;

    reset_n    = 1'b0;
    uart_rx_en = 1'b1;
    uart_rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, uart_rx_data}, 32'd0);
    chk("reset_valid", {31'd0, uart_rx_valid}, 32'd0);
    chk("reset_ferr", {31'd0, uart_rx_frame_err}, 32'd0);
    chk("reset_busy", {31'd0, uart_rx_busy}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    send(8'hA5, 1'b1);
    idle(5);

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(5);

    // 3-cycle glitch must abort in START without any strobe
    uart_rxd = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_rx_busy) bcnt++;
      if (i == 2) uart_rxd = 1'b1;
    end
    chk("glitch_busy_le5", {31'd0, (bcnt >= 1 && bcnt <= 5)}, 32'd1);
    idle(5);

    send(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    chk("wait_idle_busy", {31'd0, uart_rx_busy}, 32'd1);
    idle(5);
    chk("wait_idle_exit", {31'd0, uart_rx_busy}, 32'd0);

    v = {1'b1, 8'h5A, 1'b0};
    drive_bits(v, 5);
    uart_rx_en = 1'b0;
    v = v >> 5;
    drive_bits(v, 5);
    chk("disabled_busy", {31'd0, uart_rx_busy}, 32'd0);
    idle(2 * CPB);
    uart_rx_en = 1'b1;
    idle(CPB);
    send(8'h81, 1'b1);
    idle(5);

    v = {1'b1, 8'h77, 1'b0};
    drive_bits(v, 4);
    reset_n = 1'b0;
    #1;
    chk("midreset_data", {24'd0, uart_rx_data}, 32'd0);
    chk("midreset_valid", {31'd0, uart_rx_valid}, 32'd0);
    chk("midreset_ferr", {31'd0, uart_rx_frame_err}, 32'd0);
    chk("midreset_busy", {31'd0, uart_rx_busy}, 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    idle(2 * CPB);
    send(8'h42, 1'b1);
    idle(5);

    for (int k = 0; k < 30; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 6) != 0);
      send(b, ok);
      if (ok) idle($urandom_range(0, 12));
      else    idle(CPB + $urandom_range(0, 5));
    end

    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
